// File: rtl/kband_cmd_pkg.sv
// Shared definitions for the KBand command decoder: command word fields,
// opcodes, decoder states and status word bit positions.
package kband_cmd_pkg;

  // Command word layout
  localparam int TOG_BIT = 31;
  localparam int OP_HI   = 30;
  localparam int OP_LO   = 28;
  localparam int ARG_HI  = 27;

  // Opcodes
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_SRST  = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_START = 3'd3;
  localparam logic [2:0] OP_STEP  = 3'd4;
  localparam logic [2:0] OP_ABORT = 3'd5;

  // Status word layout
  localparam int ST_ACK_BIT   = 31;
  localparam int ST_BUSY_BIT  = 30;
  localparam int ST_ERR_BIT   = 29;
  localparam int ST_CBUSY_BIT = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RST   = 2'd1,
    ST_START = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  // Opcodes 6 and 7 are reserved and reported as errors.
  function automatic logic op_illegal(input logic [2:0] op);
    return (op > OP_ABORT);
  endfunction

endpackage

// File: rtl/kband_cmd_decoder.sv
// Decodes toggle-qualified host commands from a PIO level word into one-shot
// control for the KBand alignment core, and reports progress in a status word.
module kband_cmd_decoder
  import kband_cmd_pkg::*;
#(
  parameter int RST_CYCLES = 16,
  parameter int LEN_W      = 28
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      pio_word,
  output logic             core_rst,
  output logic [LEN_W-1:0] seq_len,
  output logic             start_valid,
  input  logic             start_ready,
  output logic             step_en,
  input  logic             core_busy,
  output logic [31:0]      status
);

  state_t           state;
  state_t           state_nxt;
  logic             last_tog;
  logic             ack;
  logic             err;
  logic             cbusy;
  logic [LEN_W-1:0] cnt;

  logic [2:0]       op;
  logic [LEN_W-1:0] arg;
  logic             tog_chg;
  logic             new_cmd;
  logic             abort_hit;

  assign op        = pio_word[OP_HI:OP_LO];
  assign arg       = pio_word[LEN_W-1:0];
  assign tog_chg   = (pio_word[TOG_BIT] != last_tog);
  assign new_cmd   = tog_chg && (state == ST_IDLE);
  // Only ABORT is looked at while a START or STEP is pending.
  assign abort_hit = tog_chg && (op == OP_ABORT) &&
                     ((state == ST_START) || (state == ST_STEP));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decision; the shared down-counter ends both RST and STEP at 1
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (new_cmd) begin
          case (op)
            OP_SRST:  state_nxt = ST_RST;
            OP_START: if (seq_len != '0) state_nxt = ST_START;
            OP_STEP:  if (arg != '0) state_nxt = ST_STEP;
            default:  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_RST:   if (cnt == LEN_W'(1)) state_nxt = ST_IDLE;
      ST_START: if (abort_hit || start_ready) state_nxt = ST_IDLE;
      ST_STEP:  if (abort_hit || (cnt == LEN_W'(1))) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Command capture, counter, error and acknowledge bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_tog <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      cbusy    <= 1'b0;
      cnt      <= '0;
      seq_len  <= '0;
    end else begin
      cbusy <= core_busy;

      if (new_cmd || abort_hit) last_tog <= pio_word[TOG_BIT];

      if (new_cmd) begin
        err <= op_illegal(op) || ((op == OP_START) && (seq_len == '0));
        case (op)
          OP_LOAD: seq_len <= arg;
          OP_SRST: cnt     <= LEN_W'(RST_CYCLES);
          OP_STEP: cnt     <= arg;
          default: ;
        endcase
      end else if (abort_hit) begin
        err <= 1'b0;
        cnt <= '0;
      end else if ((state == ST_RST) || (state == ST_STEP)) begin
        cnt <= cnt - LEN_W'(1);
      end

      // An abort acknowledges its own toggle, which last_tog only takes this edge.
      if (state == ST_IDLE)
        ack <= last_tog;
      else if (state_nxt == ST_IDLE)
        ack <= abort_hit ? pio_word[TOG_BIT] : last_tog;
    end
  end

  // Outputs decoded from registered state only, so start_ready never reaches start_valid
  always_comb begin
    core_rst    = (state == ST_RST);
    start_valid = (state == ST_START);
    step_en     = (state == ST_STEP);
    status      = {ack, (state != ST_IDLE), err, cbusy, 28'(cnt)};
  end

endmodule

// File: tb/tb_kband_cmd_decoder.sv
// Directed bench for kband_cmd_decoder: drives host command words and checks
// outputs and status against expected values held in the bench.
module tb_kband_cmd_decoder;
  import kband_cmd_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] pio_word;
  logic        core_rst;
  logic [27:0] seq_len;
  logic        start_valid;
  logic        start_ready;
  logic        step_en;
  logic        core_busy;
  logic [31:0] status;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  kband_cmd_decoder #(.RST_CYCLES(16), .LEN_W(28)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pio_word   (pio_word),
    .core_rst   (core_rst),
    .seq_len    (seq_len),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .step_en    (step_en),
    .core_busy  (core_busy),
    .status     (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", obs, 32'hxxxx_xxxx);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic write_cmd(input logic tog, input logic [2:0] op, input logic [27:0] arg);
    pio_word = {tog, op, arg};
    tick();
  endtask

  // Walk contiguous step pulses, comparing the live count against the scoreboard.
  task automatic collect_steps(input int bound, output int pulses);
    pulses = 0;
    for (int i = 0; i < bound; i++) begin
      if (!step_en) break;
      pulses++;
      sb_pop({4'h0, status[27:0]});
      if (pulses == bound) break;
      tick();
    end
  endtask

  initial begin
    int n;
    int hs;
    logic busy_ok;

    reset_n     = 1'b0;
    pio_word    = 32'h0;
    start_ready = 1'b0;
    core_busy   = 1'b0;
    repeat (3) tick();
    chk("rst_status", status, 32'h0);
    chk("rst_ctrl", {29'h0, core_rst, start_valid, step_en}, 32'h0);
    chk("rst_seq_len", {4'h0, seq_len}, 32'h0);
    reset_n = 1'b1;
    tick();

    // LOAD 0x123 with toggle 1
    pio_word = 32'hA000_0123;
    tick();
    chk("load_seq_len", {4'h0, seq_len}, 32'h0000_0123);
    chk("load_ack_not_yet", status, 32'h0);
    tick();
    chk("load_status", status, 32'h8000_0000);

    // SRST: 16 clocks of core_rst, busy throughout, ack on the falling clock
    write_cmd(1'b0, OP_SRST, 28'h0);
    n = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!core_rst) break;
      n++;
      if (status[ST_BUSY_BIT] !== 1'b1) busy_ok = 1'b0;
      tick();
    end
    chk("srst_len", n, 32'd16);
    chk("srst_busy", {31'h0, busy_ok}, 32'h1);
    chk("srst_ack", status, 32'h0);

    // START with ready held low for the first 5 valid cycles
    write_cmd(1'b1, OP_START, 28'h0);
    n = 0;
    hs = 0;
    for (int i = 0; i < 50; i++) begin
      if (!start_valid) break;
      n++;
      start_ready = (n >= 6);
      if (start_valid && start_ready) hs++;
      tick();
    end
    start_ready = 1'b0;
    chk("start_valid_len", n, 32'd6);
    chk("start_handshakes", hs, 32'd1);
    chk("start_ack", status, 32'h8000_0000);

    // START with zero length is refused with an error
    write_cmd(1'b0, OP_LOAD, 28'h0);
    tick();
    chk("load_zero", {4'h0, seq_len}, 32'h0);
    write_cmd(1'b1, OP_START, 28'h0);
    chk("start0_no_valid", {31'h0, start_valid}, 32'h0);
    tick();
    chk("start0_no_valid2", {31'h0, start_valid}, 32'h0);
    chk("start0_status", status, 32'hA000_0000);

    // STEP 10: ten pulses, count 10 down to 1 while pulsing, then 0
    for (int k = 10; k >= 1; k--) sb_push("step10_cnt", k);
    write_cmd(1'b0, OP_STEP, 28'd10);
    collect_steps(20, n);
    chk("step10_pulses", n, 32'd10);
    chk("step10_sb_empty", sb.size(), 32'd0);
    chk("step10_status", status, 32'h0);

    // STEP 0: no pulses, immediate ack
    write_cmd(1'b1, OP_STEP, 28'd0);
    chk("step0_no_pulse", {31'h0, step_en}, 32'h0);
    tick();
    chk("step0_status", status, 32'h8000_0000);

    // STEP 1000 aborted after 20 pulses
    for (int k = 1000; k > 980; k--) sb_push("step1000_cnt", k);
    write_cmd(1'b0, OP_STEP, 28'd1000);
    collect_steps(20, n);
    chk("abort_pre_pulses", n, 32'd20);
    write_cmd(1'b1, OP_ABORT, 28'h0);
    chk("abort_step_off", {31'h0, step_en}, 32'h0);
    chk("abort_status", status, 32'h8000_0000);
    tick();
    chk("abort_stays_idle", {31'h0, step_en}, 32'h0);
    chk("abort_status2", status, 32'h8000_0000);

    // Illegal opcode 7
    write_cmd(1'b0, 3'd7, 28'h0);
    tick();
    chk("op7_status", status, 32'h2000_0000);

    // core_busy is reflected, registered
    core_busy = 1'b1;
    tick();
    chk("core_busy_status", status, 32'h3000_0000);
    core_busy = 1'b0;
    tick();

    // Async reset mid-STEP, then the pending toggle=1 command runs again
    write_cmd(1'b1, OP_STEP, 28'd50);
    tick();
    tick();
    chk("pre_reset_step", {31'h0, step_en}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midrst_status", status, 32'h0);
    chk("midrst_ctrl", {29'h0, core_rst, start_valid, step_en}, 32'h0);
    #2;
    reset_n = 1'b1;
    for (int k = 50; k >= 1; k--) sb_push("rerun_cnt", k);
    tick();
    collect_steps(60, n);
    chk("rerun_pulses", n, 32'd50);
    chk("rerun_sb_empty", sb.size(), 32'd0);
    chk("rerun_status", status, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kband_cmd_decoder.md
# kband_cmd_decoder

Sits directly downstream of the 32-bit Avalon PIO output register, whose `out_port` carries host commands. Turns the static level word into one-shot commands for the KBand alignment core:
- a toggle bit detects each new write;
- an opcode field selects the action;
- a state machine drives timed soft reset, length load, a start handshake and counted step bursts.

A 32-bit status word with an acknowledge toggle is returned for the host to read through an input PIO.

## Interface
- `RST_CYCLES`, default 16: length of the soft-reset pulse, in clocks (≥1).
- `LEN_W`, default 28: width of the argument, length and count fields (≤28).
- `clk`  in  1: clock.
- `reset_n`  in  1: reset; asynchronous, active-low.
- `pio_word`  in  32: command word from the PIO out_port, same clock domain.
  - [31] toggle.
  - [30:28] opcode.
  - [27:0] argument.
- `core_rst`  out  1: soft reset to the core, active-high.
- `seq_len`  out  LEN_W: registered sequence length.
- `start_valid`  out  1: start request to the core.
- `start_ready`  in  1: the core accepts the start request.
- `step_en`  out  1: single-cycle step enable.
- `core_busy`  in  1: the core is processing.
- `status`  out  32: status word to the input PIO.
  - [31] ack toggle.
  - [30] decoder busy.
  - [29] error.
  - [28] core_busy.
  - [27:0] remaining step count.

## Operation
- Reset values:
  - `core_rst` = 0, `seq_len` = 0, `start_valid` = 0, `step_en` = 0.
  - `status` = 0; the ack toggle and the internal `last_tog` register are both 0.
  - The state machine is in IDLE.
- A new command is detected in IDLE when `pio_word[31]` != `last_tog`. On detection:
  - `last_tog` <= `pio_word[31]`;
  - opcode and argument are latched, so later changes to `pio_word` are ignored until the decoder returns to IDLE.
- Opcodes:
  - 0 NOP: acknowledge only.
  - 1 SRST: go to RST; hold `core_rst` = 1 for exactly `RST_CYCLES` clocks, then acknowledge.
  - 2 LOAD: `seq_len` <= arg[LEN_W-1:0]; acknowledge.
  - 3 START: go to START; hold `start_valid` = 1 until a cycle with `start_valid && start_ready`, then acknowledge. If `seq_len` == 0, do not start; set error and acknowledge.
  - 4 STEP: go to STEP; counter <= arg; assert `step_en` once per clock while counter != 0, decrementing each cycle. Counter reaching 0 acknowledges. arg = 0 acknowledges immediately, with no pulses.
  - 5 ABORT: stops a pending START or STEP (see below). Received in IDLE, it behaves as a NOP.
  - 6 and 7: illegal; set error and acknowledge.
- ABORT while in START or STEP:
  - it is the only command examined outside IDLE, and is detected by a toggle change;
  - it drops `start_valid` / `step_en` on the next clock, clears the counter and returns to IDLE;
  - it acknowledges the ABORT toggle; the aborted command is never separately acknowledged.
- Acknowledge: `status[31]` <= `last_tog`, registered on the cycle the state machine returns to IDLE. The host polls until `status[31]` equals the toggle it wrote.
- Error bit: set by an illegal opcode or a START with zero length; cleared by the next legal command's detection.
- `status[30]` = 1 whenever the state is not IDLE.
- `status[28]` = `core_busy`, registered.
- `status[27:0]` = current step counter, zero-extended.
- States and transitions:
  - IDLE -> RST / START / STEP, or stays in IDLE for a single-cycle command.
  - RST -> IDLE after `RST_CYCLES`.
  - START -> IDLE on handshake or ABORT.
  - STEP -> IDLE when the counter reaches 0 or on ABORT.
- Other non-ABORT toggle changes received while not in IDLE are ignored (`last_tog` is not updated). They are therefore detected once the decoder returns to IDLE.

## Timing
- Detection latency: 1 clock from the `pio_word` change to the state change or latched output.
- LOAD/NOP ack: visible 2 clocks after the `pio_word` change.
- SRST: `core_rst` rises 1 clock after detection. It is high for exactly `RST_CYCLES` clocks; the ack appears on the clock it falls.
- STEP N: exactly N contiguous `step_en` pulses, the first 1 clock after detection. The ack appears the cycle after the last pulse.
- START:
  - `start_valid` is held steady, with no combinational path from `start_ready`;
  - it falls the clock after the handshake, and the ack updates on that same clock.
- An async `reset_n` assertion mid-command returns everything to its reset values immediately. The host must resynchronise: `last_tog` = 0, so a PIO toggle of 1 still pending is re-executed after reset.

## Structure
- Shared package `kband_cmd_pkg`: opcode localparams (`OP_NOP`…`OP_ABORT`), field bit positions, state enum, status bit indices. These are reused by host-side drivers and the bench.
- A single module; no sub-module needed. The reset/step down-counter is shared between the RST and STEP states.

## Test plan
- LOAD: `pio_word` = 0xA000_0123 -> `seq_len` = 0x123; `status[31]` = 1, error = 0.
- SRST with `RST_CYCLES` = 16: `core_rst` high exactly 16 clocks; ack toggles when it falls; busy = 1 throughout.
- START with `start_ready` low for 5 clocks, then high: `start_valid` stays high 6 clocks, one handshake, then ack. With `seq_len` = 0: no `start_valid`, error = 1.
- STEP arg = 10 -> exactly 10 consecutive `step_en` pulses, `status[27:0]` counting 10 -> 0. STEP arg = 0 -> immediate ack, no pulses.
- STEP 1000, then ABORT after 20 pulses -> `step_en` stops within 1 clock; count = 0; ack matches the ABORT toggle. Opcode 7 -> error = 1, ack.
- `reset_n` pulsed mid-STEP -> all outputs 0 immediately; the pending toggle = 1 is re-executed after release.
